// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    // 9 * 255 * 255 = 585225 fits in 20 bits
    localparam int ACC_W = 20;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        MAC    = 2'd1,
        EMIT   = 2'd2
    } state_t;

    // Gaussian-like kernel; taps sum to 1000 so SHIFT=10 gives roughly unity gain
    localparam int DEFAULT_COEF [9] = '{95, 118, 95, 118, 148, 118, 95, 118, 95};

endpackage

// File: rtl/conv_line_buffer.sv
// One-line pixel delay: dout is the pixel written at the same column one line earlier.
// Latency: Img_W accepted pixels; read is combinational at the current column.
// Backpressure: advances only when we is high, so it stalls with the pixel stream.
module conv_line_buffer #(
    parameter int Datawidth = 8,
    parameter int Img_W     = 512,
    parameter int AW        = (Img_W > 1) ? $clog2(Img_W) : 1
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [Datawidth-1:0] din,
    output logic [Datawidth-1:0] dout
);

    logic [Datawidth-1:0] mem [Img_W];

    // Old contents at this column leave before the new pixel overwrites them
    assign dout = mem[addr];

    // Write the incoming pixel into the column slot it just vacated
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/conv3x3_mac_sched.sv
// 3x3 convolution over a raster stream using one shared external multiplier.
// Latency: window-completing pixel accepted at edge T, result valid in cycle T+10.
// Backpressure: in_ready low through MAC and EMIT; result held until out_ready.
module conv3x3_mac_sched
    import conv_pkg::*;
#(
    parameter int Datawidth = 8,
    parameter int Img_W     = 512,
    parameter int Img_H     = 512,
    parameter int SHIFT     = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [Datawidth-1:0]   in_img_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_addr,
    input  logic [Datawidth-1:0]   cfg_data,
    output logic [Datawidth-1:0]   mul_a,
    output logic [Datawidth-1:0]   mul_b,
    input  logic [2*Datawidth-1:0] mul_p,
    output logic [Datawidth-1:0]   out_img_data,
    output logic                   conv_valid,
    input  logic                   out_ready,
    output logic                   frame_done
);

    localparam int CW = (Img_W > 1) ? $clog2(Img_W) : 1;
    localparam int RW = (Img_H > 1) ? $clog2(Img_H) : 1;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << Datawidth) - 1);

    state_t               state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [Datawidth-1:0] win_q  [9];
    logic [Datawidth-1:0] win_d  [9];
    logic [Datawidth-1:0] coef_q [9];
    logic [Datawidth-1:0] coef_d [9];
    logic [3:0]           k_q, k_d;
    logic [3:0]           k_nxt;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     acc_sum;
    logic [ACC_W-1:0]     acc_shr;
    logic [Datawidth-1:0] sat_pix;
    logic [Datawidth-1:0] mul_a_q, mul_a_d;
    logic [Datawidth-1:0] mul_b_q, mul_b_d;
    logic [Datawidth-1:0] out_q, out_d;
    logic                 conv_valid_q, conv_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic                 pix_acc;
    logic [Datawidth-1:0] lb0_dout;
    logic [Datawidth-1:0] lb1_dout;

    assign pix_acc = (state_q == ACCEPT) && in_valid;

    // lb0 yields the pixel one line above, lb1 the pixel two lines above
    conv_line_buffer #(.Datawidth(Datawidth), .Img_W(Img_W), .AW(CW)) u_lb0 (
        .clk  (clk),
        .we   (pix_acc),
        .addr (col_q),
        .din  (in_img_data),
        .dout (lb0_dout)
    );

    conv_line_buffer #(.Datawidth(Datawidth), .Img_W(Img_W), .AW(CW)) u_lb1 (
        .clk  (clk),
        .we   (pix_acc),
        .addr (col_q),
        .din  (lb0_dout),
        .dout (lb1_dout)
    );

    assign k_nxt   = k_q + 4'd1;
    assign acc_sum = acc_q + ACC_W'(mul_p);
    assign acc_shr = acc_sum >> SHIFT;
    assign sat_pix = (acc_shr > SAT_MAX) ? '1 : acc_shr[Datawidth-1:0];

    // Next-state logic: pixel intake, nine-step MAC sequencing, result handshake
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        win_d        = win_q;
        coef_d       = coef_q;
        k_d          = k_q;
        acc_d        = acc_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        out_d        = out_q;
        conv_valid_d = conv_valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            ACCEPT: begin
                // a same-cycle coefficient write is visible to the window it completes
                if (cfg_we && (cfg_addr <= 4'd8)) begin
                    coef_d[cfg_addr] = cfg_data;
                end
                if (in_valid) begin
                    for (int m = 0; m < 3; m++) begin
                        win_d[3*m]   = win_q[3*m+1];
                        win_d[3*m+1] = win_q[3*m+2];
                    end
                    win_d[2] = lb1_dout;
                    win_d[5] = lb0_dout;
                    win_d[8] = in_img_data;

                    if (col_q == CW'(Img_W - 1)) begin
                        col_d = '0;
                        row_d = (row_q == RW'(Img_H - 1)) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end

                    if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
                        state_d = MAC;
                        k_d     = 4'd0;
                        acc_d   = '0;
                        mul_a_d = win_d[0];
                        mul_b_d = coef_d[0];
                    end
                end
            end

            MAC: begin
                acc_d = acc_sum;
                if (k_q == 4'd8) begin
                    state_d      = EMIT;
                    mul_a_d      = '0;
                    mul_b_d      = '0;
                    out_d        = sat_pix;
                    conv_valid_d = 1'b1;
                end else begin
                    k_d     = k_nxt;
                    mul_a_d = win_q[k_nxt];
                    mul_b_d = coef_q[k_nxt];
                end
            end

            EMIT: begin
                if (out_ready) begin
                    state_d      = ACCEPT;
                    conv_valid_d = 1'b0;
                    // counters only wrap to (0,0) after the frame's final pixel
                    if ((row_q == '0) && (col_q == '0)) begin
                        frame_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    // State registers; reset abandons any window in flight and restarts the frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCEPT;
            row_q        <= '0;
            col_q        <= '0;
            k_q          <= 4'd0;
            acc_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            out_q        <= '0;
            conv_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i]  <= '0;
                coef_q[i] <= Datawidth'(DEFAULT_COEF[i]);
            end
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            out_q        <= out_d;
            conv_valid_q <= conv_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
            coef_q       <= coef_d;
        end
    end

    assign in_ready     = (state_q == ACCEPT);
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign out_img_data = out_q;
    assign conv_valid   = conv_valid_q;
    assign frame_done   = frame_done_q;

endmodule

// File: doc/conv3x3_mac_sched.md
# conv3x3_mac_sched

Sequencer that time-shares one external 8x8 (approximate) multiplier to compute a 3x3 convolution over a raster-streamed image. It buffers two image lines, forms the 3x3 window, issues the nine window×coefficient products to the shared multiplier one per cycle, accumulates them, scales and saturates the sum, and emits one output pixel per valid window. It sits between the pixel source and the image sink, and its multiplier port connects to whichever multiplier variant is under evaluation (Dadda, truncated, etc.).

## Interface
Parameters:
- Datawidth, 8: pixel and coefficient width.
- Img_W, 512: pixels per line.
- Img_H, 512: lines per frame.
- SHIFT, 10: right shift applied to the accumulated sum.

Ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_img_data  in  Datawidth  input pixel, raster order.
- in_valid  in  1  in_img_data is valid.
- in_ready  out  1  block accepts a pixel this cycle.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  4  coefficient index k = 3*m + n (m = row offset, n = column offset; 0 = oldest).
- cfg_data  in  Datawidth  coefficient value.
- mul_a, mul_b  out  Datawidth each  multiplier operands (window pixel, coefficient).
- mul_p  in  2*Datawidth  product from the external combinational multiplier.
- out_img_data  out  Datawidth  result pixel.
- conv_valid  out  1  out_img_data is valid.
- out_ready  in  1  sink accepts the result.
- frame_done  out  1  one-cycle pulse after the last output of a frame is accepted.

## Operation
- States: ACCEPT, MAC, EMIT. Reset state is ACCEPT. Reset values: in_ready 1, conv_valid 0, out_img_data 0, frame_done 0, mul_a/mul_b 0, row/col counters 0, acc 0, coefficients = {95,118,95,118,148,118,95,118,95}. Line-buffer contents are not reset.
- ACCEPT: in_ready = 1. On in_valid, the pixel at (row, col) is written into the line buffers and shifted into the 3x3 window, and col/row advance (col wraps at Img_W-1, row wraps at Img_H-1). If row ≥ 2 and col ≥ 2, the next state is MAC; otherwise the block stays in ACCEPT.
- MAC: in_ready = 0. Step counter k = 0..8. mul_a = win[k] and mul_b = coef[k] are driven from registers. acc = acc + mul_p on each edge. After k = 8, go to EMIT.
- Arithmetic: acc is 20 bits (9·255·255 = 585225 < 2^20), cleared on entry to MAC. Result = acc >> SHIFT, saturated to 2^Datawidth − 1.
- EMIT: conv_valid = 1 and out_img_data is held stable until out_ready is high. On the handshake, go to ACCEPT. If the output accepted was the last window of the frame, pulse frame_done on the following cycle.
- Outputs per frame: (Img_W−2)·(Img_H−2). Border windows are not produced.
- cfg writes take effect only in ACCEPT. They are ignored in MAC/EMIT and when cfg_addr > 8. A cfg write and a pixel accepted in the same cycle are both performed.
- Reset asserted in any state aborts the current window, drops any pending output, and restarts the frame at (0,0).

## Timing
- A pixel that completes a window is accepted at edge T. MAC occupies cycles T+1..T+9. conv_valid is first high in cycle T+10.
- With out_ready held high, throughput is 1 window-completing pixel per 11 cycles. Pixels that do not complete a window are accepted 1 per cycle.
- in_ready is combinationally low throughout MAC and EMIT.
- mul_p must settle within the same cycle that its operands are driven; the product is sampled at the end of that cycle.

## Structure
- Package conv_pkg: ACC_W = 20, the state enum {ACCEPT, MAC, EMIT}, and the default Gaussian coefficient array.
- Sub-module conv_line_buffer: an Img_W-deep, Datawidth-wide shift/RAM line delay, instantiated twice.
- The multiplier is not instantiated inside this block. It connects through the mul_a, mul_b and mul_p ports.

## Test plan
- Img_W = Img_H = 4, SHIFT = 10, default coefficients, constant 100 image -> exactly 4 outputs of 97 (100000 >> 10), then frame_done pulses once.
- Write coefficients to all 0 except coef[4] = 1, SHIFT = 0, ramp image p = 4r + c -> outputs 5, 6, 9, 10 (the window centres).
- All coefficients 255, all pixels 255, SHIFT = 0 -> every output saturates to 255.
- Hold out_ready low for 20 cycles in EMIT -> conv_valid and out_img_data stay stable, in_ready stays 0, no pixel is lost.
- Assert reset during MAC step 4 -> conv_valid 0, in_ready 1 the next cycle. A new 4x4 frame then produces 4 correct outputs.
- Issue a cfg write during MAC -> it is ignored. The same write issued in ACCEPT changes the next window's result.
